// File: rtl/trng_pll_lock_ctrl.sv
// trng_pll_lock_ctrl
// Sequences and supervises the 12->96 MHz PLL that clocks the TRNG sampling core.
// Holds the PLL in reset for a fixed window, waits (bounded) for LOCK, requires LOCK
// to stay high for a stability window, then releases the TRNG core reset. Failed
// attempts are retried up to RETRY_MAX times before latching FAIL; lock losses while
// running are counted (saturating) for health logging.
//
// Ports
//   REFERENCECLK  in   12 MHz reference clock, sole clock
//   RESET         in   async active-low block reset
//   PLL_LOCK      in   PLL LOCK, asynchronous (2-flop synchronised)
//   REARM         in   sync pulse, restarts the sequence from FAIL only
//   PLL_RESETB    out  PLL RESETB, active low
//   CORE_RESETN   out  TRNG core reset, active low (mirrors READY)
//   READY         out  PLL locked and stable, core released
//   FAIL          out  retries exhausted, sticky until REARM or RESET
//   LOSS_COUNT    out  lock losses seen while running, saturating at 255
module trng_pll_lock_ctrl #(
    parameter int unsigned RESET_CYCLES  = 16,
    parameter int unsigned LOCK_TIMEOUT  = 4096,
    parameter int unsigned STABLE_CYCLES = 256,
    parameter int unsigned RETRY_MAX     = 7
) (
    input  logic       REFERENCECLK,
    input  logic       RESET,
    input  logic       PLL_LOCK,
    input  logic       REARM,
    output logic       PLL_RESETB,
    output logic       CORE_RESETN,
    output logic       READY,
    output logic       FAIL,
    output logic [7:0] LOSS_COUNT
);

    // One shared counter serves all timed states; size it for the longest window.
    localparam int unsigned MAX_AB  = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned MAX_CNT = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CNT > 2) ? $clog2(MAX_CNT) : 1;
    localparam int unsigned RETRY_W = (RETRY_MAX > 1) ? $clog2(RETRY_MAX + 1) : 1;

    localparam logic [CNT_W-1:0]   RST_LAST   = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TMO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STB_LAST   = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(RETRY_MAX);

    typedef enum logic [2:0] {
        S_RST    = 3'd0,
        S_WAIT   = 3'd1,
        S_STABLE = 3'd2,
        S_RUN    = 3'd3,
        S_FAIL   = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [7:0]         loss_d;
    logic               lock_meta, lock_s;
    logic               pll_resetb_d, ready_d, fail_d;

    // Two-flop synchroniser for the asynchronous PLL LOCK output.
    always_ff @(posedge REFERENCECLK or negedge RESET) begin
        if (!RESET) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= PLL_LOCK;
            lock_s    <= lock_meta;
        end
    end

    // Next-state, counter, retry and loss-count logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        loss_d  = LOSS_COUNT;
        case (state_q)
            S_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT: begin
                // Lock seen on the timeout cycle still wins; no retry is spent.
                if (lock_s) begin
                    state_d = S_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TMO_LAST) begin
                    cnt_d = '0;
                    if (retry_q == RETRY_LAST) begin
                        state_d = S_FAIL;
                    end else begin
                        retry_d = retry_q + RETRY_W'(1);
                        state_d = S_RST;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STABLE: begin
                // A lock glitch restarts the wait with a fresh timeout but keeps retry.
                if (!lock_s) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else if (cnt_q == STB_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    retry_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RUN: begin
                if (!lock_s) begin
                    state_d = S_RST;
                    cnt_d   = '0;
                    retry_d = '0;
                    if (LOSS_COUNT != 8'hFF) begin
                        loss_d = LOSS_COUNT + 8'd1;
                    end
                end
            end
            S_FAIL: begin
                if (REARM) begin
                    state_d = S_RST;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            end
            default: begin
                state_d = S_RST;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decoded from the next state so they change on the transition edge.
    always_comb begin
        pll_resetb_d = 1'b0;
        ready_d      = 1'b0;
        fail_d       = 1'b0;
        case (state_d)
            S_WAIT, S_STABLE: pll_resetb_d = 1'b1;
            S_RUN: begin
                pll_resetb_d = 1'b1;
                ready_d      = 1'b1;
            end
            S_FAIL:  fail_d = 1'b1;
            default: pll_resetb_d = 1'b0;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge REFERENCECLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= S_RST;
            cnt_q       <= '0;
            retry_q     <= '0;
            LOSS_COUNT  <= 8'd0;
            PLL_RESETB  <= 1'b0;
            CORE_RESETN <= 1'b0;
            READY       <= 1'b0;
            FAIL        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            LOSS_COUNT  <= loss_d;
            PLL_RESETB  <= pll_resetb_d;
            CORE_RESETN <= ready_d;
            READY       <= ready_d;
            FAIL        <= fail_d;
        end
    end

endmodule

// File: tb/tb_trng_pll_lock_ctrl.sv
// tb_trng_pll_lock_ctrl
// Directed bench for trng_pll_lock_ctrl with RESET_CYCLES/LOCK_TIMEOUT/STABLE_CYCLES/
// RETRY_MAX = 4/32/8/2. A timestamp-based phase model predicts every output on every
// cycle; hand-computed cycle counts pin the model at the key timing points.
module tb_trng_pll_lock_ctrl;

    localparam int RC = 4;
    localparam int LT = 32;
    localparam int SC = 8;
    localparam int RM = 2;

    logic       REFERENCECLK = 1'b0;
    logic       RESET        = 1'b0;
    logic       PLL_LOCK     = 1'b0;
    logic       REARM        = 1'b0;
    logic       PLL_RESETB;
    logic       CORE_RESETN;
    logic       READY;
    logic       FAIL;
    logic [7:0] LOSS_COUNT;

    int checks   = 0;
    int failures = 0;

    trng_pll_lock_ctrl #(
        .RESET_CYCLES (RC),
        .LOCK_TIMEOUT (LT),
        .STABLE_CYCLES(SC),
        .RETRY_MAX    (RM)
    ) dut (
        .REFERENCECLK(REFERENCECLK),
        .RESET       (RESET),
        .PLL_LOCK    (PLL_LOCK),
        .REARM       (REARM),
        .PLL_RESETB  (PLL_RESETB),
        .CORE_RESETN (CORE_RESETN),
        .READY       (READY),
        .FAIL        (FAIL),
        .LOSS_COUNT  (LOSS_COUNT)
    );

    initial forever #5 REFERENCECLK = ~REFERENCECLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Phases are timed by absolute edge numbers; lock is seen two edges late.
    typedef enum {PH_RST, PH_WAIT, PH_STABLE, PH_RUN, PH_FAIL} phase_e;
    phase_e m_phase  = PH_RST;
    int     m_cyc    = 0;
    int     m_start  = 0;
    int     m_fails  = 0;
    int     m_losses = 0;
    bit     m_h1     = 1'b0;
    bit     m_h2     = 1'b0;

    function automatic void m_reset();
        m_phase  = PH_RST;
        m_start  = m_cyc;
        m_fails  = 0;
        m_losses = 0;
        m_h1     = 1'b0;
        m_h2     = 1'b0;
    endfunction

    always @(negedge RESET) m_reset();

    always @(posedge REFERENCECLK) begin
        bit ls;
        m_cyc++;
        if (!RESET) begin
            m_reset();
        end else begin
            ls   = m_h2;
            m_h2 = m_h1;
            m_h1 = PLL_LOCK;
            case (m_phase)
                PH_RST: if (m_cyc - m_start == RC) begin
                    m_phase = PH_WAIT;
                    m_start = m_cyc;
                end
                PH_WAIT: if (ls) begin
                    m_phase = PH_STABLE;
                    m_start = m_cyc;
                end else if (m_cyc - m_start == LT) begin
                    if (m_fails == RM) begin
                        m_phase = PH_FAIL;
                    end else begin
                        m_fails++;
                        m_phase = PH_RST;
                        m_start = m_cyc;
                    end
                end
                PH_STABLE: if (!ls) begin
                    m_phase = PH_WAIT;
                    m_start = m_cyc;
                end else if (m_cyc - m_start == SC) begin
                    m_phase = PH_RUN;
                    m_fails = 0;
                end
                PH_RUN: if (!ls) begin
                    m_phase = PH_RST;
                    m_start = m_cyc;
                    if (m_losses < 255) m_losses++;
                end
                PH_FAIL: if (REARM) begin
                    m_phase = PH_RST;
                    m_start = m_cyc;
                    m_fails = 0;
                end
                default: m_phase = PH_RST;
            endcase
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge REFERENCECLK) begin
        check("PLL_RESETB", 32'(PLL_RESETB),
              (m_phase == PH_WAIT || m_phase == PH_STABLE || m_phase == PH_RUN) ? 32'd1 : 32'd0);
        check("READY", 32'(READY), (m_phase == PH_RUN) ? 32'd1 : 32'd0);
        check("CORE_RESETN", 32'(CORE_RESETN), (m_phase == PH_RUN) ? 32'd1 : 32'd0);
        check("FAIL", 32'(FAIL), (m_phase == PH_FAIL) ? 32'd1 : 32'd0);
        check("LOSS_COUNT", 32'(LOSS_COUNT), 32'(m_losses));
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge REFERENCECLK);
    endtask

    // Negedges counted from 'start' until PLL_RESETB is seen high (bounded).
    task automatic wait_resetb(input int start, output int n);
        n = start;
        do begin
            @(negedge REFERENCECLK);
            n++;
        end while (!PLL_RESETB && n < start + 200);
    endtask

    task automatic wait_ready(input int start, output int n);
        n = start;
        do begin
            @(negedge REFERENCECLK);
            n++;
        end while (!READY && n < start + 200);
    endtask

    // Drop RESET between edges.
    task automatic drop_reset();
        @(posedge REFERENCECLK);
        #2 RESET = 1'b0;
    endtask

    initial begin
        int n;
        int n2;
        bit rt [1:160];
        bit ft [1:160];
        int rises;
        int hi;
        int first_fail;
        int rise_pos [3];
        logic c1, c2, c3;

        RESET    = 1'b0;
        PLL_LOCK = 1'b0;
        REARM    = 1'b0;

        // 1 Nominal bring-up
        tick(3);
        check("reset_PLL_RESETB", 32'(PLL_RESETB), 32'd0);
        check("reset_READY", 32'(READY), 32'd0);
        check("reset_LOSS_COUNT", 32'(LOSS_COUNT), 32'd0);
        RESET = 1'b1;
        wait_resetb(0, n);
        check("nominal_rst_len", 32'(n), 32'd4);
        tick(10);
        PLL_LOCK = 1'b1;
        wait_ready(0, n);
        check("nominal_ready_t_plus_10", 32'(n), 32'd11);
        check("nominal_core_resetn", 32'(CORE_RESETN), 32'd1);
        check("nominal_fail", 32'(FAIL), 32'd0);
        check("nominal_loss", 32'(LOSS_COUNT), 32'd0);

        // 2 Lock stuck low: three attempts then FAIL
        drop_reset();
        PLL_LOCK = 1'b0;
        tick(2);
        RESET = 1'b1;
        for (int i = 1; i <= 160; i++) begin
            @(negedge REFERENCECLK);
            rt[i] = PLL_RESETB;
            ft[i] = FAIL;
        end
        rises      = 0;
        hi         = 0;
        first_fail = 0;
        for (int i = 1; i <= 160; i++) begin
            if (rt[i]) hi++;
            if (i > 1 && rt[i] && !rt[i-1]) begin
                if (rises < 3) rise_pos[rises] = i;
                rises++;
            end
            if (ft[i] && first_fail == 0) first_fail = i;
        end
        check("timeout_rise_count", 32'(rises), 32'd3);
        check("timeout_rise0", 32'(rise_pos[0]), 32'd4);
        check("timeout_rise1", 32'(rise_pos[1]), 32'd40);
        check("timeout_rise2", 32'(rise_pos[2]), 32'd76);
        check("timeout_high_cycles", 32'(hi), 32'd96);
        check("timeout_first_fail", 32'(first_fail), 32'd108);
        check("fail_holds_pll_reset", 32'(rt[160]), 32'd0);
        check("fail_sticky", 32'(ft[160]), 32'd1);

        // 3 Rearm from FAIL, then REARM ignored in RUN
        PLL_LOCK = 1'b1;
        REARM    = 1'b1;
        @(negedge REFERENCECLK);
        REARM = 1'b0;
        check("rearm_fail_clear", 32'(FAIL), 32'd0);
        check("rearm_pll_reset", 32'(PLL_RESETB), 32'd0);
        wait_ready(1, n);
        check("rearm_ready_time", 32'(n), 32'd14);
        REARM = 1'b1;
        @(negedge REFERENCECLK);
        REARM = 1'b0;
        tick(3);
        check("rearm_in_run_ready", 32'(READY), 32'd1);
        check("rearm_in_run_fail", 32'(FAIL), 32'd0);

        // 4 Lock glitch while STABLE (counter at 5)
        drop_reset();
        tick(2);
        RESET = 1'b1;
        tick(10);
        check("glitch_in_stable", 32'({PLL_RESETB, READY}), 32'd2);
        PLL_LOCK = 1'b0;
        @(negedge REFERENCECLK);
        PLL_LOCK = 1'b1;
        wait_ready(11, n);
        check("glitch_ready_time", 32'(n), 32'd22);

        // 5 Repeated lock loss in RUN
        for (int i = 0; i < 300; i++) begin
            PLL_LOCK = 1'b0;
            @(negedge REFERENCECLK);
            PLL_LOCK = 1'b1;
            c1 = CORE_RESETN;
            @(negedge REFERENCECLK);
            c2 = CORE_RESETN;
            @(negedge REFERENCECLK);
            c3 = CORE_RESETN;
            check("loss_core_timing", 32'({c1, c2, c3}), 32'd6);
            check("loss_count_step", 32'(LOSS_COUNT), 32'((i + 1 > 255) ? 255 : i + 1));
            wait_ready(3, n);
            check("loss_relock_time", 32'(n), 32'd16);
        end
        check("loss_saturated", 32'(LOSS_COUNT), 32'd255);

        // 6 Async reset mid-STABLE
        PLL_LOCK = 1'b0;
        @(negedge REFERENCECLK);
        PLL_LOCK = 1'b1;
        tick(9);
        check("mid_stable_state", 32'({PLL_RESETB, READY}), 32'd2);
        drop_reset();
        #1;
        check("async_PLL_RESETB", 32'(PLL_RESETB), 32'd0);
        check("async_CORE_RESETN", 32'(CORE_RESETN), 32'd0);
        check("async_READY", 32'(READY), 32'd0);
        check("async_FAIL", 32'(FAIL), 32'd0);
        check("async_LOSS_COUNT", 32'(LOSS_COUNT), 32'd0);
        tick(2);
        RESET = 1'b1;
        wait_resetb(0, n);
        check("restart_rst_len", 32'(n), 32'd4);
        wait_ready(n, n2);
        check("restart_ready_time", 32'(n2), 32'd13);
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
